// File: rtl/ac_evt.sv
// ac_evt: event stage behind the analog comparator.
// Resynchronises acout, glitch-filters it with a programmable hold-off,
// detects selected edges and keeps a sticky irq/ovf pair plus a saturating
// edge counter. Synchronous active-high reset.
// Optional: define AC_EVT_TIMESTAMP_EN to add the ts_cap timestamp port.
module ac_evt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acenable,
  input  logic              acout,
  input  logic [1:0]        cfg_edge,
  input  logic [FILT_W-1:0] cfg_filt,
  input  logic              irq_clr,
  input  logic              cnt_clr,
  output logic              acout_filt,
  output logic              evt,
  output logic              irq,
  output logic              ovf,
  output logic [CNT_W-1:0]  edge_cnt
`ifdef AC_EVT_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0]  ts_cap
`endif
);

  typedef enum logic [1:0] {LO, LO_PEND, HI, HI_PEND} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [FILT_W-1:0]      cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Resynchroniser; held cleared while the comparator is disabled.
  // NOTE: reset and enable are sampled on clk, so they sit in the same
  // priority branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || !acenable) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], acout};
    end
  end

  // Filter FSM: a new level must persist for cfg_filt+1 samples before it
  // commits; the committing edge also produces the registered evt pulse.
  // NOTE: cfg_filt is compared live with >=, so shortening it while a
  // change is pending commits on the very next sample.
  always_ff @(posedge clk) begin
    if (rst || !acenable) begin
      state      <= LO;
      cnt        <= '0;
      acout_filt <= 1'b0;
      evt        <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        LO: begin
          if (s) begin
            if (cfg_filt == '0) begin
              state      <= HI;
              acout_filt <= 1'b1;
              evt        <= cfg_edge[0];
            end else begin
              state <= LO_PEND;
              cnt   <= FILT_W'(1);
            end
          end
        end
        LO_PEND: begin
          if (!s) begin
            state <= LO;
            cnt   <= '0;
          end else if (cnt >= cfg_filt) begin
            state      <= HI;
            cnt        <= '0;
            acout_filt <= 1'b1;
            evt        <= cfg_edge[0];
          end else begin
            cnt <= cnt + FILT_W'(1);
          end
        end
        HI: begin
          if (!s) begin
            if (cfg_filt == '0) begin
              state      <= LO;
              acout_filt <= 1'b0;
              evt        <= cfg_edge[1];
            end else begin
              state <= HI_PEND;
              cnt   <= FILT_W'(1);
            end
          end
        end
        HI_PEND: begin
          if (s) begin
            state <= HI;
            cnt   <= '0;
          end else if (cnt >= cfg_filt) begin
            state      <= LO;
            cnt        <= '0;
            acout_filt <= 1'b0;
            evt        <= cfg_edge[1];
          end else begin
            cnt <= cnt + FILT_W'(1);
          end
        end
        default: begin
          state      <= LO;
          cnt        <= '0;
          acout_filt <= 1'b0;
        end
      endcase
    end
  end

  // Sticky interrupt and overflow flags; an event wins over a clear for irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (evt) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
      if (irq_clr) begin
        ovf <= 1'b0;
      end else if (evt && irq) begin
        ovf <= 1'b1;
      end
    end
  end

  // Saturating edge counter; a clear coincident with an event counts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= CNT_W'(evt);
    end else if (evt && (edge_cnt != '1)) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

`ifdef AC_EVT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q;

  // Free-running wrap-around timestamp, captured on every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q   <= '0;
      ts_cap <= '0;
    end else begin
      ts_q <= ts_q + CNT_W'(1);
      if (evt) begin
        ts_cap <= ts_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ac_evt.sv
// tb_ac_evt: scoreboard bench for ac_evt (SYNC_STAGES=2, FILT_W=4, CNT_W=4).
// Every driven acout change that should be reported pushes its expected
// level and due cycle; a negedge monitor pops and compares on each evt.
module tb_ac_evt;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             acenable;
  logic             acout;
  logic [1:0]       cfg_edge;
  logic [3:0]       cfg_filt;
  logic             irq_clr;
  logic             cnt_clr;
  logic             acout_filt;
  logic             evt;
  logic             irq;
  logic             ovf;
  logic [CNT_W-1:0] edge_cnt;
`ifdef AC_EVT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cap;
`endif

  ac_evt #(
    .SYNC_STAGES(2),
    .FILT_W     (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .acenable  (acenable),
    .acout     (acout),
    .cfg_edge  (cfg_edge),
    .cfg_filt  (cfg_filt),
    .irq_clr   (irq_clr),
    .cnt_clr   (cnt_clr),
    .acout_filt(acout_filt),
    .evt       (evt),
    .irq       (irq),
    .ovf       (ovf),
    .edge_cnt  (edge_cnt)
`ifdef AC_EVT_TIMESTAMP_EN
    ,
    .ts_cap    (ts_cap)
`endif
  );

  typedef struct {
    logic rise;
    int   due;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;
  logic             ts_pend = 1'b0;
  logic [CNT_W-1:0] ts_exp  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; matches the DUT timestamp counter.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rise, input int lat);
    exp_t e_new;
    e_new.rise = rise;
    e_new.due  = cyc + lat;
    q.push_back(e_new);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
    tick(1);
    check("drain", q.size(), 0);
    q.delete();
  endtask

  // Event monitor: each evt must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
`ifdef AC_EVT_TIMESTAMP_EN
      if (ts_pend) begin
        check("ts_cap_load", ts_cap, ts_exp);
        ts_pend = 1'b0;
      end
`endif
      if (evt) begin
        if (q.size() == 0) begin
          check("evt_unexpected", evt, 1'b0);
        end else begin
          e_mon = q.pop_front();
          check("evt_level", acout_filt, e_mon.rise);
          check("evt_cycle", cyc, e_mon.due);
        end
        ts_exp  = cyc[CNT_W-1:0];
        ts_pend = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    acenable = 1'b1;
    acout    = 1'b0;
    cfg_edge = 2'b01;
    cfg_filt = 4'd0;
    irq_clr  = 1'b0;
    cnt_clr  = 1'b0;
    tick(3);
    check("rst_filt", acout_filt, 1'b0);
    check("rst_evt", evt, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_cnt", edge_cnt, 0);
`ifdef AC_EVT_TIMESTAMP_EN
    check("rst_ts", ts_cap, 0);
`endif
    rst = 1'b0;

    // Rising edge, no filter, landing on cycle 100.
    while (cyc < 97) tick(1);
    acout = 1'b1;
    push(1'b1, 3);
    drain();
    check("t1_filt", acout_filt, 1'b1);
    check("t1_irq", irq, 1'b1);
    check("t1_ovf", ovf, 1'b0);
    check("t1_cnt", edge_cnt, 1);
`ifdef AC_EVT_TIMESTAMP_EN
    check("t1_ts", ts_cap, 4'(100));
    tick(50);
    check("t1_ts_hold", ts_cap, 4'(100));
`endif
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    check("t1_irq_clr", irq, 1'b0);
    // Falling edge not selected: level follows, no event.
    acout = 1'b0;
    tick(6);
    check("t1_fall_filt", acout_filt, 1'b0);
    check("t1_fall_cnt", edge_cnt, 1);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    check("t1_cnt_clr", edge_cnt, 0);

    // Glitch rejection with cfg_filt=3.
    cfg_filt = 4'd3;
    cfg_edge = 2'b11;
    acout = 1'b1; tick(3); acout = 1'b0;
    tick(10);
    check("t2_glitch_filt", acout_filt, 1'b0);
    check("t2_glitch_irq", irq, 1'b0);
    acout = 1'b1;
    push(1'b1, 6);
    tick(4);
    acout = 1'b0;
    push(1'b0, 6);
    drain();
    check("t2_cnt", edge_cnt, 2);
    check("t2_irq", irq, 1'b1);
    check("t3_ovf_set", ovf, 1'b1);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    check("t3_clr_irq", irq, 1'b0);
    check("t3_clr_ovf", ovf, 1'b0);

    // irq_clr coincident with evt.
    cfg_filt = 4'd0;
    acout = 1'b1;
    push(1'b1, 3);
    drain();
    check("t3_pre_irq", irq, 1'b1);
    check("t3_pre_ovf", ovf, 1'b0);
    acout = 1'b0;
    push(1'b0, 3);
    tick(3);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    check("t3_coinc_irq", irq, 1'b1);
    check("t3_coinc_ovf", ovf, 1'b0);
    check("t3_cnt", edge_cnt, 4);
    drain();

    // Saturation at 15 with CNT_W=4.
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    check("t4_clr", edge_cnt, 0);
    for (int i = 0; i < 17; i++) begin
      acout = ~acout;
      push(acout, 3);
      tick(5);
    end
    drain();
    check("t4_sat", edge_cnt, 15);
    check("t4_ovf", ovf, 1'b1);
    acout = ~acout;
    push(acout, 3);
    tick(3);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    check("t4_clr_evt", edge_cnt, 1);
    drain();

    // Lowering cfg_filt mid-pend commits on the next sample.
    cfg_filt = 4'd5;
    acout = 1'b1;
    tick(5);
    cfg_filt = 4'd2;
    push(1'b1, 1);
    drain();
    check("t5_lower_filt", acout_filt, 1'b1);
    cfg_filt = 4'd0;
    acout = 1'b0;
    push(1'b0, 3);
    drain();
    check("t5_lower_cnt", edge_cnt, 3);

    // Enable abort mid-LO_PEND, then re-enable with acout high.
    cfg_filt = 4'd5;
    acout = 1'b1;
    tick(5);
    acenable = 1'b0;
    tick(3);
    check("t5_abort_filt", acout_filt, 1'b0);
    check("t5_abort_irq", irq, 1'b1);
    check("t5_abort_ovf", ovf, 1'b1);
    check("t5_abort_cnt", edge_cnt, 3);
    acenable = 1'b1;
    push(1'b1, 8);
    drain();
    check("t5_reen_filt", acout_filt, 1'b1);
    check("t5_reen_cnt", edge_cnt, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
